// File: rtl/avalon_streaming_arbiter.sv
// Purpose: packet-locked round-robin arbiter merging NUM_IN Avalon-ST sinks into one source.
// Latency: 1 cycle from accepted sink beat to aso_valid; one idle arbitration cycle between packets.
// Backpressure: asi_ready of the granted port follows out_free (!aso_valid || aso_ready); others held at 0.
//
// Ports:
//   clk, reset                        - single clock, synchronous active-high reset
//   asi_valid/data/startofpacket/endofpacket, asi_ready - NUM_IN sink ports (ready latency 0)
//   port_enable                       - per-port mask, consulted only when choosing a new packet
//   aso_valid/data/channel/startofpacket/endofpacket, aso_ready - merged source (ready latency 0)
//   busy                              - high while a packet is locked
//   grant_id                          - current or most recently granted port
module avalon_streaming_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        asi_valid,
    input  logic [NUM_IN*DATA_W-1:0] asi_data,
    input  logic [NUM_IN-1:0]        asi_startofpacket,
    input  logic [NUM_IN-1:0]        asi_endofpacket,
    output logic [NUM_IN-1:0]        asi_ready,
    input  logic [NUM_IN-1:0]        port_enable,
    output logic                     aso_valid,
    output logic [DATA_W-1:0]        aso_data,
    output logic [CH_W-1:0]          aso_channel,
    output logic                     aso_startofpacket,
    output logic                     aso_endofpacket,
    input  logic                     aso_ready,
    output logic                     busy,
    output logic [CH_W-1:0]          grant_id
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   grant_id_q, grant_id_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic              aso_valid_q, aso_valid_d;
    logic [DATA_W-1:0] aso_data_q, aso_data_d;
    logic [CH_W-1:0]   aso_channel_q, aso_channel_d;
    logic              aso_sop_q, aso_sop_d;
    logic              aso_eop_q, aso_eop_d;

    logic [NUM_IN-1:0] req;
    logic [CH_W-1:0]   cand;
    logic              found;
    logic              out_free;
    logic              accept;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              sel_sop;
    logic              sel_eop;

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        aso_valid_d   = aso_valid_q;
        aso_data_d    = aso_data_q;
        aso_channel_d = aso_channel_q;
        aso_sop_d     = aso_sop_q;
        aso_eop_d     = aso_eop_q;
        req           = asi_valid & port_enable;
        cand          = '0;
        found         = 1'b0;
        out_free      = !aso_valid_q || aso_ready;
        accept        = 1'b0;
        asi_ready     = '0;
        sel_valid     = 1'b0;
        sel_data      = '0;
        sel_sop       = 1'b0;
        sel_eop       = 1'b0;

        // Constant-index mux of the granted sink port.
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_id_q == CH_W'(i)) begin
                sel_valid = asi_valid[i];
                sel_data  = asi_data[i*DATA_W +: DATA_W];
                sel_sop   = asi_startofpacket[i];
                sel_eop   = asi_endofpacket[i];
                asi_ready[i] = (state_q == ST_LOCKED) && out_free && !reset;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Round-robin: search upward starting one past the last packet owner.
                for (int k = 1; k <= NUM_IN; k++) begin
                    cand = CH_W'((int'(last_grant_q) + k) % NUM_IN);
                    if (!found && req[cand]) begin
                        found      = 1'b1;
                        grant_id_d = cand;
                    end
                end
                if (found) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                accept = sel_valid && out_free && !reset;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            aso_valid_d   = 1'b1;
            aso_data_d    = sel_data;
            aso_channel_d = grant_id_q;
            aso_sop_d     = sel_sop;
            aso_eop_d     = sel_eop;
            // EOP alone ends the lock; SOP is forwarded but never interpreted.
            if (sel_eop) begin
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
        end else if (aso_valid_q && aso_ready) begin
            aso_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= '0;
            last_grant_q  <= CH_W'(NUM_IN - 1);
            aso_valid_q   <= 1'b0;
            aso_data_q    <= '0;
            aso_channel_q <= '0;
            aso_sop_q     <= 1'b0;
            aso_eop_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            aso_valid_q   <= aso_valid_d;
            aso_data_q    <= aso_data_d;
            aso_channel_q <= aso_channel_d;
            aso_sop_q     <= aso_sop_d;
            aso_eop_q     <= aso_eop_d;
        end
    end

    assign aso_valid         = aso_valid_q;
    assign aso_data          = aso_data_q;
    assign aso_channel       = aso_channel_q;
    assign aso_startofpacket = aso_sop_q;
    assign aso_endofpacket   = aso_eop_q;
    assign busy              = (state_q == ST_LOCKED) && !reset;
    assign grant_id          = grant_id_q;

endmodule

// File: doc/avalon_streaming_arbiter.md
AVALON_STREAMING_ARBITER -- requirements
Module: avalon_streaming_arbiter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of Avalon-ST sink ports (2..8).
REQ-002 SHALL have parameter DATA_W, default 8: data width per beat.
REQ-003 SHALL have parameter CH_W, default 2: channel width, equal to clog2(NUM_IN).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port asi_valid, input, NUM_IN: per-port beat valid.
REQ-007 SHALL have port asi_data, input, NUM_IN*DATA_W: port i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port asi_startofpacket, input, NUM_IN: per-port SOP flag.
REQ-009 SHALL have port asi_endofpacket, input, NUM_IN: per-port EOP flag.
REQ-010 SHALL have port asi_ready, output, NUM_IN: per-port ready, ready latency 0.
REQ-011 SHALL have port port_enable, input, NUM_IN: per-port arbitration enable mask.
REQ-012 SHALL have port aso_valid, output, 1: source beat valid.
REQ-013 SHALL have port aso_data, output, DATA_W: source data.
REQ-014 SHALL have port aso_channel, output, CH_W: index of the port that supplied the beat.
REQ-015 SHALL have ports aso_startofpacket and aso_endofpacket, output, 1 each: forwarded SOP and EOP flags.
REQ-016 SHALL have port aso_ready, input, 1: downstream ready, ready latency 0.
REQ-017 SHALL have port busy, output, 1: high while the FSM is in LOCKED.
REQ-018 SHALL have port grant_id, output, CH_W: current or most recent granted port.

Function
REQ-019 SHALL use a two-state FSM, IDLE and LOCKED, with registers grant_id and last_grant.
REQ-020 SHALL, in IDLE, form the request set as asi_valid & port_enable; if the set is non-empty, grant_id SHALL become the first requester searching upward from last_grant+1 mod NUM_IN, and the next state SHALL be LOCKED.
REQ-021 SHALL hold all asi_ready at 0 in IDLE, so one arbitration cycle separates packets.
REQ-022 SHALL define out_free = !aso_valid || aso_ready.
REQ-023 SHALL, in LOCKED, drive asi_ready[grant_id] = out_free and every other asi_ready bit to 0.
REQ-024 SHALL treat a sink beat as accepted when asi_valid[g] && asi_ready[g] at a clock edge.
REQ-025 SHALL, on an accepted beat, register data, SOP and EOP into aso_*, set aso_channel = grant_id and set aso_valid = 1; output latency is exactly 1 cycle.
REQ-026 SHALL clear aso_valid when aso_valid && aso_ready and no new beat is accepted in the same cycle.
REQ-027 SHALL hold every aso_* output stable while aso_valid && !aso_ready.
REQ-028 SHALL sustain 1 beat/cycle within a packet while aso_ready = 1.
REQ-029 SHALL, on an accepted beat with EOP = 1, set last_grant = grant_id and return the FSM to IDLE next cycle; a single-beat packet (SOP = EOP = 1) follows the same rule.
REQ-030 SHALL not check SOP; the packet boundary is EOP only.
REQ-031 SHALL keep a packet locked to completion if port_enable[grant_id] drops mid-packet; the mask affects only IDLE arbitration.
REQ-032 SHALL, when port_enable = 0, never leave IDLE and keep asi_ready = 0.
REQ-033 SHALL, when a valid drops mid-packet (bubble), stay LOCKED and wait with no timeout.
REQ-034 SHALL wrap the round-robin pointer from NUM_IN-1 to 0.

Reset
REQ-035 SHALL, while reset = 1 at a clock edge, set: FSM = IDLE, grant_id = 0, last_grant = NUM_IN-1, aso_valid = 0, aso_data = 0, aso_channel = 0, aso_startofpacket = 0, aso_endofpacket = 0.
REQ-036 SHALL hold asi_ready = 0 and busy = 0 during and after reset until the next grant.
REQ-037 SHALL, on reset asserted mid-packet, discard the in-flight packet and output beat; after reset the arbiter restarts with port 0 highest priority.

Verification
REQ-038 SHALL cover: a reset pulse of 2 cycles -> all outputs 0, asi_ready = 0; the first request from ports {1,3} grants port 1.
REQ-039 SHALL cover: ports 0..3 each valid with a 3-beat packet, aso_ready = 1 -> output order is channels 0,1,2,3; each packet is 3 consecutive beats; a 1-cycle gap between packets.
REQ-040 SHALL cover: port 2 sending 4 beats 0xA0..0xA3 with aso_ready toggling 1,0,1,0,... -> data is unchanged while stalled, all 4 beats arrive in order, and asi_ready[2] = 0 whenever aso_valid && !aso_ready.
REQ-041 SHALL cover: port_enable = 4'b0101 with all valid -> only channels 0 and 2, alternating; clearing bit 2 mid-packet still completes that packet.
REQ-042 SHALL cover: reset asserted on beat 2 of a 5-beat packet from port 3 -> aso_valid = 0 next cycle, and port 0 wins the next arbitration when ports 0 and 3 both request.
REQ-043 SHALL cover: a single-beat packet (SOP = EOP = 1) on port 1 only, repeated -> one beat every 2 cycles, aso_channel = 1 each time.
